veer_trace_fifo: RTL
====================

Name: veer_trace_fifo

Overview:
- Downstream consumer of the EL2 core's instruction-trace port (trace_rv_i_*) in the testbench.
- Captures every retired-instruction, exception or interrupt trace record into a DEPTH-entry FIFO.
- Presents records one at a time on a valid/ready interface to the bench's trace logger or host bridge.
- Counts records lost to back-pressure and flags the first record after a loss so the consumer can detect gaps.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
CNT_W, 16, drop counter width.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
trace_rv_i_valid_ip  in  1  trace record valid this cycle
trace_rv_i_insn_ip  in  32  instruction word
trace_rv_i_address_ip  in  32  instruction address
trace_rv_i_exception_ip  in  1  exception flag
trace_rv_i_ecause_ip  in  5  exception/interrupt cause
trace_rv_i_interrupt_ip  in  1  interrupt flag
trace_rv_i_tval_ip  in  32  trap value
flush  in  1  discard all buffered records
clr_drop  in  1  clear drop counter and overflow flag
out_valid  out  1  head record valid
out_ready  in  1  consumer accepts head record
out_insn  out  32  head insn
out_addr  out  32  head address
out_exc  out  1  head exception flag
out_ecause  out  5  head cause
out_intr  out  1  head interrupt flag
out_tval  out  32  head tval
out_gap  out  1  one or more records were dropped immediately before this one
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one record dropped since reset or clr_drop
drop_cnt  out  CNT_W  dropped-record count, saturating

Behaviour:
- Reset values: out_valid=0, level=0, overflow=0, drop_cnt=0, gap_pending=0. All out_* data outputs are 0 while the FIFO is empty.
- Storage: circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits; level is a separate counter. Pointers wrap DEPTH-1 -> 0.
- Push: push = trace_rv_i_valid_ip & (level<DEPTH | pop). Record fields and gap_pending are written at wr_ptr.
- Pop: pop = out_valid & out_ready. Head is first-word-fall-through and combinational from storage at rd_ptr. out_valid = (level!=0).
- Latency: a record pushed in cycle N appears on out_* in cycle N+1.
- Back-pressure: out_valid/out_* stay stable until popped.
- Full and pop in the same cycle: the push is accepted and level is unchanged.
- Full with no pop: the record is dropped. drop_cnt increments, saturating at all-ones; overflow is set; gap_pending is set.
- gap_pending is cleared on the next accepted push; that record carries gap=1.
- Push and pop on an empty FIFO: the push is accepted and the pop cannot occur (out_valid=0).
- Level update: level += push - pop.
- flush: takes priority over push and pop in that cycle. Next cycle: level=0, pointers=0, gap_pending=0. drop_cnt and overflow are unchanged. The flush-cycle input record is discarded and not counted.
- clr_drop: next cycle drop_cnt=0 and overflow=0. If a drop occurs in the same cycle, the clear wins the counter (drop_cnt=0), but overflow is set to 1 and gap_pending is set.
- rst mid-operation: all state returns to reset values on the next edge. Buffered records are lost and not counted.

Optional Feature:
- Macro: VEER_TRACE_TSTAMP_EN.
- With the macro defined:
  - A 32-bit free-running cycle counter is added; reset 0, increments every cycle, wraps 0xFFFF_FFFF -> 0.
  - Its value in the push cycle is stored per entry and output on extra port out_tstamp (out, 32).
  - The counter is not affected by flush.
- Without the macro: no counter, no out_tstamp port, no timestamp storage.

Test Plan:
1. Single record: valid with insn=0x00000013, addr=0x80000000 at cycle 5, out_ready=1 -> out_valid=1 in cycle 6 with matching fields and gap=0; level returns to 0 in cycle 7.
2. Fill: 16 consecutive records with out_ready=0 -> level=16. 3 more records -> drop_cnt=3, overflow=1. Release out_ready -> 16 records drained in order. Next pushed record has out_gap=1, the one after it gap=0.
3. Full with simultaneous push and pop: level=16, out_ready=1, valid=1 -> no drop, level stays 16, drop_cnt=0.
4. Wrap-around: 40 records streamed with out_ready toggling every cycle -> all 40 received in order; pointers wrap without loss.
5. flush at level=7 while valid=1 -> level=0 and out_valid=0 the next cycle; drop_cnt unchanged. clr_drop with drop_cnt=5 -> drop_cnt=0, overflow=0.
6. (VEER_TRACE_TSTAMP_EN) Records pushed at cycles 10 and 13 after reset -> out_tstamp=10 then 13. Counter forced near 0xFFFFFFFF -> wraps to 0.

Source files
------------

// File: rtl/veer_trace_fifo.sv
// -----------------------------------------------------------------------------
// veer_trace_fifo
//
// Buffers EL2 instruction-trace records (retire / exception / interrupt) in a
// DEPTH-entry circular FIFO. Records are presented first-word-fall-through on
// a valid/ready interface. Records that arrive while the FIFO is full and not
// draining are dropped. Dropped records are counted in a saturating counter,
// set a sticky overflow flag, and mark the next accepted record with out_gap.
//
// Optional build macro: VEER_TRACE_TSTAMP_EN
//   Adds a free-running 32-bit cycle counter. Its value in the push cycle is
//   stored with each record and presented on out_tstamp.
//
// Parameters:
//   DEPTH  FIFO entries (power of 2, >= 2)
//   CNT_W  drop counter width
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   trace_rv_i_*             incoming trace record (valid + fields)
//   flush                    discard all buffered records
//   clr_drop                 clear drop counter and overflow flag
//   out_valid / out_ready    head record handshake
//   out_insn .. out_tval     head record fields (zero while empty)
//   out_gap                  records were lost immediately before this one
//   out_tstamp               push-cycle timestamp (macro builds only)
//   level                    current occupancy
//   overflow                 sticky drop indicator
//   drop_cnt                 saturating dropped-record count
// -----------------------------------------------------------------------------
module veer_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_rv_i_valid_ip,
  input  logic [31:0]              trace_rv_i_insn_ip,
  input  logic [31:0]              trace_rv_i_address_ip,
  input  logic                     trace_rv_i_exception_ip,
  input  logic [4:0]               trace_rv_i_ecause_ip,
  input  logic                     trace_rv_i_interrupt_ip,
  input  logic [31:0]              trace_rv_i_tval_ip,
  input  logic                     flush,
  input  logic                     clr_drop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_insn,
  output logic [31:0]              out_addr,
  output logic                     out_exc,
  output logic [4:0]               out_ecause,
  output logic                     out_intr,
  output logic [31:0]              out_tval,
  output logic                     out_gap,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
`ifdef VEER_TRACE_TSTAMP_EN
  output logic [31:0]              out_tstamp,
`endif
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;
  // Record layout: {gap, intr, exc, ecause, tval, addr, insn}
  localparam int REC_W = 32 + 32 + 32 + 5 + 1 + 1 + 1;

  // Control state
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;
  logic             gap_pending_q, gap_pending_d;

  // Storage (no reset: contents are only observed through level/rd_ptr)
  logic [REC_W-1:0] mem_q [DEPTH];

  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] head;

  assign full      = (level_q == LW'(DEPTH));
  assign out_valid = (level_q != '0);

  // Flush suppresses both sides of the handshake; the flush-cycle record is
  // neither stored nor counted as a drop. A pop frees a slot in the same
  // cycle, so a full FIFO that is draining still accepts the new record.
  assign pop  = out_valid & out_ready & ~flush;
  assign push = trace_rv_i_valid_ip & ~flush & (~full | pop);
  assign drop = trace_rv_i_valid_ip & ~flush & full & ~pop;

  assign wr_rec = {gap_pending_q, trace_rv_i_interrupt_ip, trace_rv_i_exception_ip,
                   trace_rv_i_ecause_ip, trace_rv_i_tval_ip, trace_rv_i_address_ip,
                   trace_rv_i_insn_ip};

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    drop_cnt_d    = drop_cnt_q;
    overflow_d    = overflow_q;
    gap_pending_d = gap_pending_q;

    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      level_d       = '0;
      gap_pending_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (drop)      gap_pending_d = 1'b1;
      else if (push) gap_pending_d = 1'b0;
    end

    // Clear wins the counter; a same-cycle drop still leaves overflow set.
    if (clr_drop)                drop_cnt_d = '0;
    else if (drop && !(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + CNT_W'(1);

    if (drop)          overflow_d = 1'b1;
    else if (clr_drop) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      drop_cnt_q    <= '0;
      overflow_q    <= 1'b0;
      gap_pending_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      drop_cnt_q    <= drop_cnt_d;
      overflow_q    <= overflow_d;
      gap_pending_q <= gap_pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_rec;
  end

  // First-word-fall-through head; data is forced to zero while empty.
  assign head       = mem_q[rd_ptr_q];
  assign out_insn   = out_valid ? head[31:0]   : '0;
  assign out_addr   = out_valid ? head[63:32]  : '0;
  assign out_tval   = out_valid ? head[95:64]  : '0;
  assign out_ecause = out_valid ? head[100:96] : '0;
  assign out_exc    = out_valid & head[101];
  assign out_intr   = out_valid & head[102];
  assign out_gap    = out_valid & head[103];

  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

`ifdef VEER_TRACE_TSTAMP_EN
  logic [31:0] tstamp_q;
  logic [31:0] ts_mem_q [DEPTH];
  logic [31:0] ts_head;

  // Free-running; flush does not disturb it, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) tstamp_q <= '0;
    else     tstamp_q <= tstamp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (push) ts_mem_q[wr_ptr_q] <= tstamp_q;
  end

  assign ts_head    = ts_mem_q[rd_ptr_q];
  assign out_tstamp = out_valid ? ts_head : '0;
`endif

endmodule
